// File: rtl/cpu_sequencer.sv
// Top-level control FSM for the single-issue core: sequences PC launch, fetch, execute and
// memory-wait phases, drives the PC/IR/regfile/memory strobes and keeps benchmark counters.
module cpu_sequencer #(
    parameter int unsigned CNT_BITS    = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start_req,
    input  logic                pc_done,
    input  logic                is_mem,
    input  logic                is_load,
    input  logic                is_branch,
    input  logic                branch_cond,
    input  logic                writes_reg,
    input  logic                mem_ack,
    output logic                pc_start,
    output logic                next_ins,
    output logic                jump_flag,
    output logic                ir_load,
    output logic                reg_we,
    output logic                mem_req,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic [CNT_BITS-1:0] instr_count
);

    localparam int unsigned TMO_BITS = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(MEM_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StFetch,
        StExec,
        StMemWait,
        StHalt
    } state_t;

    state_t              state_q;
    logic [TMO_BITS-1:0] tmo_q;

    always_comb begin
        pc_start  = 1'b0;
        next_ins  = 1'b0;
        jump_flag = 1'b0;
        ir_load   = 1'b0;
        reg_we    = 1'b0;
        mem_req   = 1'b0;
        unique case (state_q)
            StLaunch: pc_start = 1'b1;
            StFetch:  ir_load  = 1'b1;
            StExec: begin
                if (!pc_done) begin
                    if (is_mem) begin
                        mem_req = 1'b1;
                    end else begin
                        next_ins  = 1'b1;
                        jump_flag = is_branch & branch_cond;
                        reg_we    = writes_reg;
                    end
                end
            end
            StMemWait: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_ins = 1'b1;
                    reg_we   = is_load;
                end
            end
            default: ;
        endcase
        busy = (state_q == StLaunch) || (state_q == StFetch) ||
               (state_q == StExec)   || (state_q == StMemWait);
        done = (state_q == StHalt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            error       <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            unique case (state_q)
                StIdle, StHalt: begin
                    // Counters and error clear on launch, so they read zero during LAUNCH.
                    if (start_req) begin
                        state_q     <= StLaunch;
                        error       <= 1'b0;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end
                end
                StLaunch: state_q <= StFetch;
                StFetch:  state_q <= StExec;
                StExec: begin
                    if (pc_done) begin
                        state_q <= StHalt;
                    end else if (is_mem) begin
                        tmo_q   <= '0;
                        state_q <= StMemWait;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StMemWait: begin
                    // An ack arriving in the expiry cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state_q <= StFetch;
                    end else if ((MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                        error   <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (busy && (state_q != StLaunch) && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (next_ins && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected strobe vectors are queued as stimulus
// is driven and popped when the outputs are sampled on the falling edge.
module tb_cpu_sequencer;

    localparam int unsigned CNT_BITS    = 4;
    localparam int unsigned MEM_TIMEOUT = 4;

    // Input vector: {start_req, pc_done, is_mem, is_load, is_branch, branch_cond, writes_reg, mem_ack}
    localparam logic [7:0] I_STR = 8'h80, I_PCD = 8'h40, I_MEM = 8'h20, I_LD  = 8'h10;
    localparam logic [7:0] I_BR  = 8'h08, I_BC  = 8'h04, I_WR  = 8'h02, I_ACK = 8'h01;
    // Output vector: {pc_start, next_ins, jump_flag, ir_load, reg_we, mem_req, busy, done, error}
    localparam logic [8:0] O_PCS = 9'h100, O_NXT = 9'h080, O_JMP = 9'h040, O_IRL = 9'h020;
    localparam logic [8:0] O_RWE = 9'h010, O_MRQ = 9'h008, O_BSY = 9'h004, O_DON = 9'h002;
    localparam logic [8:0] O_ERR = 9'h001;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [7:0]          in_vec;
    logic                start_req, pc_done, is_mem, is_load, is_branch, branch_cond;
    logic                writes_reg, mem_ack;
    logic                pc_start, next_ins, jump_flag, ir_load, reg_we, mem_req;
    logic                busy, done, error;
    logic [CNT_BITS-1:0] cycle_count, instr_count;
    logic [8:0]          out_vec;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stim_in[$];
    logic [8:0] stim_exp[$];
    logic [8:0] exp_q[$];

    assign {start_req, pc_done, is_mem, is_load, is_branch, branch_cond, writes_reg, mem_ack} = in_vec;
    assign out_vec = {pc_start, next_ins, jump_flag, ir_load, reg_we, mem_req, busy, done, error};

    cpu_sequencer #(
        .CNT_BITS   (CNT_BITS),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_req  (start_req),
        .pc_done    (pc_done),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_branch  (is_branch),
        .branch_cond(branch_cond),
        .writes_reg (writes_reg),
        .mem_ack    (mem_ack),
        .pc_start   (pc_start),
        .next_ins   (next_ins),
        .jump_flag  (jump_flag),
        .ir_load    (ir_load),
        .reg_we     (reg_we),
        .mem_req    (mem_req),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic add(input logic [7:0] in, input logic [8:0] exp);
        stim_in.push_back(in);
        stim_exp.push_back(exp);
    endtask

    task automatic clear_table();
        stim_in.delete();
        stim_exp.delete();
    endtask

    task automatic test_reset();
        in_vec  = I_STR;
        reset_n = 1'b0;
        #3;
        checks++;
        if (out_vec !== 9'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b need %b", out_vec, 9'h000);
        end
        checks++;
        if ({cycle_count, instr_count} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d need 0/0", cycle_count, instr_count);
        end
        @(posedge clock); #1;
        in_vec  = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_alu_run();
        logic [8:0] e;
        clear_table();
        add(I_STR, '0);
        add('0, O_PCS | O_BSY);
        for (int k = 0; k < 3; k++) begin
            add('0, O_IRL | O_BSY);
            add(I_WR, O_NXT | O_RWE | O_BSY);
        end
        add('0, O_IRL | O_BSY);
        add(I_PCD | I_WR, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL alu_run step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd8 || instr_count !== 4'd3) begin
            errors++;
            $display("FAIL alu_run_counts: got %0d/%0d need 8/3", cycle_count, instr_count);
        end
    endtask

    task automatic test_branch();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add('0, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_BR | I_BC | I_WR, O_NXT | O_JMP | O_RWE | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_BR, O_NXT | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_BC | I_WR, O_NXT | O_RWE | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_PCD | I_BR | I_BC, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL branch step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd8 || instr_count !== 4'd3) begin
            errors++;
            $display("FAIL branch_counts: got %0d/%0d need 8/3", cycle_count, instr_count);
        end
    endtask

    // Load then store, each acked in the 4th MEM_WAIT cycle, which is also the timeout cycle.
    task automatic test_mem();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add('0, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        for (int k = 0; k < 4; k++) add(I_MEM | I_LD, O_MRQ | O_BSY);
        add(I_MEM | I_LD | I_ACK | I_BR | I_BC, O_MRQ | O_NXT | O_RWE | O_BSY);
        add('0, O_IRL | O_BSY);
        for (int k = 0; k < 4; k++) add(I_MEM | I_WR, O_MRQ | O_BSY);
        add(I_MEM | I_WR | I_ACK, O_MRQ | O_NXT | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_PCD, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL mem step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd14 || instr_count !== 4'd2) begin
            errors++;
            $display("FAIL mem_counts: got %0d/%0d need 14/2", cycle_count, instr_count);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add('0, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_MEM, O_MRQ | O_BSY);
        for (int k = 0; k < 4; k++) add(I_MEM, O_MRQ | O_BSY);
        add('0, O_DON | O_ERR);
        add('0, O_DON | O_ERR);
        add(I_STR, O_DON | O_ERR);
        add('0, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_PCD, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd2 || instr_count !== 4'd0) begin
            errors++;
            $display("FAIL timeout_counts: got %0d/%0d need 2/0", cycle_count, instr_count);
        end
    endtask

    task automatic test_start_held();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add(I_STR, O_PCS | O_BSY);
        add(I_STR, O_IRL | O_BSY);
        add(I_STR | I_WR, O_NXT | O_RWE | O_BSY);
        add(I_STR, O_IRL | O_BSY);
        add(I_STR | I_PCD, O_BSY);
        add(I_STR, O_DON);
        add(I_STR, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_PCD, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL start_held step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd2 || instr_count !== 4'd0) begin
            errors++;
            $display("FAIL start_held_counts: got %0d/%0d need 2/0", cycle_count, instr_count);
        end
    endtask

    task automatic test_saturate();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add('0, O_PCS | O_BSY);
        for (int k = 0; k < 20; k++) begin
            add('0, O_IRL | O_BSY);
            add(I_WR, O_NXT | O_RWE | O_BSY);
        end
        add('0, O_IRL | O_BSY);
        add(I_PCD, O_BSY);
        add('0, O_DON);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL saturate step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (cycle_count !== 4'd15 || instr_count !== 4'd15) begin
            errors++;
            $display("FAIL saturate_counts: got %0d/%0d need 15/15", cycle_count, instr_count);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        clear_table();
        add(I_STR, O_DON);
        add('0, O_PCS | O_BSY);
        add('0, O_IRL | O_BSY);
        add(I_MEM | I_LD, O_MRQ | O_BSY);
        add(I_MEM | I_LD, O_MRQ | O_BSY);
        foreach (stim_in[i]) begin
            in_vec = stim_in[i];
            exp_q.push_back(stim_exp[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL async_reset step %0d: got %b need %b", i, out_vec, e);
            end
            @(posedge clock); #1;
        end
        // Now in the second MEM_WAIT cycle; drop reset between clock edges.
        in_vec = I_MEM | I_LD;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_vec !== 9'h000 || {cycle_count, instr_count} !== '0) begin
            errors++;
            $display("FAIL async_reset_now: got %b %0d/%0d need %b 0/0",
                     out_vec, cycle_count, instr_count, 9'h000);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        in_vec  = '0;
        @(negedge clock);
        checks++;
        if (out_vec !== 9'h000) begin
            errors++;
            $display("FAIL async_reset_idle: got %b need %b", out_vec, 9'h000);
        end
        @(posedge clock); #1;
        in_vec = I_STR;
        @(posedge clock); #1;
        in_vec = '0;
        @(negedge clock);
        checks++;
        if (out_vec !== (O_PCS | O_BSY)) begin
            errors++;
            $display("FAIL async_reset_relaunch: got %b need %b", out_vec, O_PCS | O_BSY);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        in_vec = '0;
        test_reset();
        test_alu_run();
        test_branch();
        test_mem();
        test_timeout();
        test_start_held();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
